// File: rtl/dram_arbiter2_pkg.sv
// Shared types and constants for the two-hart DRAM arbiter.
// Optional statistics counters are enabled by defining DRAM_ARB_STATS_EN.
package dram_arbiter2_pkg;

  localparam int unsigned CTRL_W  = 3;
  localparam int unsigned GRANT_W = 32;
  localparam int unsigned STAT_W  = 32;

  localparam logic HART0 = 1'b0;
  localparam logic HART1 = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  // Request kind and size/sign control held in a slot.
  typedef struct packed {
    logic              we;
    logic              le;
    logic [CTRL_W-1:0] ctrl;
  } req_flags_t;

  // Winner among pending harts; a tie goes to the hart that did not own last
  // when fair, otherwise to hart 0.
  function automatic logic pick_winner(input logic p0, input logic p1,
                                       input logic rr_last, input logic fair);
    logic w;
    if (p0 && p1) w = fair ? ~rr_last : HART0;
    else if (p0)  w = HART0;
    else          w = HART1;
    return w;
  endfunction

endpackage

// File: rtl/dram_arb_slot.sv
// Per-hart request slot: captures one strobe, holds pend and the read data.
module dram_arb_slot
  import dram_arbiter2_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     i_addr,
  input  logic [DW-1:0]     i_wdata,
  input  logic              i_we,
  input  logic              i_le,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic              i_done,
  input  logic [DW-1:0]     i_dram_odata,
  output logic              o_pend,
  output logic [AW-1:0]     o_addr,
  output logic [DW-1:0]     o_wdata,
  output req_flags_t        o_req,
  output logic [DW-1:0]     o_odata,
  output logic              o_busy_c
);

  logic          pend_q,  pend_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  req_flags_t    req_q,   req_d;
  logic [DW-1:0] odata_q, odata_d;
  logic          strobe_c;
  logic          capture_c;

  assign strobe_c  = i_we | i_le;
  // A strobe landing on the completion cycle refills the slot.
  assign capture_c = strobe_c & (~pend_q | i_done);

  // Next-state for the slot contents and read data.
  always_comb begin
    pend_d  = pend_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    req_d   = req_q;
    odata_d = odata_q;
    if (i_done && req_q.le) odata_d = i_dram_odata;
    if (capture_c) begin
      pend_d       = 1'b1;
      addr_d       = i_addr;
      wdata_d      = i_wdata;
      req_d.we     = i_we;
      req_d.le     = i_le & ~i_we;
      req_d.ctrl   = i_ctrl;
    end else if (i_done) begin
      pend_d = 1'b0;
    end
  end

  // Slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      req_q   <= '0;
      odata_q <= '0;
    end else begin
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      req_q   <= req_d;
      odata_q <= odata_d;
    end
  end

  assign o_pend   = pend_q;
  assign o_addr   = addr_q;
  assign o_wdata  = wdata_q;
  assign o_req    = req_q;
  assign o_odata  = odata_q;
  assign o_busy_c = strobe_c | pend_q;

endmodule

// File: rtl/dram_arbiter2.sv
// Two-hart DRAM arbiter: queues one request per hart and serialises them onto
// one controller port. Define DRAM_ARB_STATS_EN to add grant/conflict counters.
module dram_arbiter2
  import dram_arbiter2_pkg::*;
#(
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 32,
  parameter int unsigned FAIR = 1
) (
  input  logic               CLK,
  input  logic               RST_X,
  input  logic [AW-1:0]      w_h0_addr,
  input  logic [AW-1:0]      w_h1_addr,
  input  logic [DW-1:0]      w_h0_wdata,
  input  logic [DW-1:0]      w_h1_wdata,
  input  logic               w_h0_we,
  input  logic               w_h1_we,
  input  logic               w_h0_le,
  input  logic               w_h1_le,
  input  logic [CTRL_W-1:0]  w_h0_ctrl,
  input  logic [CTRL_W-1:0]  w_h1_ctrl,
  output logic               w_h0_busy,
  output logic               w_h1_busy,
  output logic [DW-1:0]      w_h0_odata,
  output logic [DW-1:0]      w_h1_odata,
  output logic [GRANT_W-1:0] w_grant,
  output logic [AW-1:0]      w_dram_addr,
  output logic [DW-1:0]      w_dram_wdata,
  output logic               w_dram_we,
  output logic               w_dram_le,
  output logic [CTRL_W-1:0]  w_dram_ctrl,
  input  logic               w_dram_busy,
  input  logic [DW-1:0]      w_dram_odata
`ifdef DRAM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]  w_stat_grant0,
  output logic [STAT_W-1:0]  w_stat_grant1,
  output logic [STAT_W-1:0]  w_stat_conflict
`endif
);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              rr_last_q, rr_last_d;
  logic [AW-1:0]     daddr_q, daddr_d;
  logic [DW-1:0]     dwdata_q, dwdata_d;
  logic [CTRL_W-1:0] dctrl_q, dctrl_d;
  logic              dwe_q, dwe_d;
  logic              dle_q, dle_d;
  logic              done_c, done0_c, done1_c;

  logic              pend0, pend1;
  logic [AW-1:0]     s0_addr, s1_addr;
  logic [DW-1:0]     s0_wdata, s1_wdata;
  req_flags_t        s0_req, s1_req, win_req_c;
  logic              win_c;

  dram_arb_slot #(.AW(AW), .DW(DW)) u_slot0 (
    .clk          (CLK),
    .rst_n        (RST_X),
    .i_addr       (w_h0_addr),
    .i_wdata      (w_h0_wdata),
    .i_we         (w_h0_we),
    .i_le         (w_h0_le),
    .i_ctrl       (w_h0_ctrl),
    .i_done       (done0_c),
    .i_dram_odata (w_dram_odata),
    .o_pend       (pend0),
    .o_addr       (s0_addr),
    .o_wdata      (s0_wdata),
    .o_req        (s0_req),
    .o_odata      (w_h0_odata),
    .o_busy_c     (w_h0_busy)
  );

  dram_arb_slot #(.AW(AW), .DW(DW)) u_slot1 (
    .clk          (CLK),
    .rst_n        (RST_X),
    .i_addr       (w_h1_addr),
    .i_wdata      (w_h1_wdata),
    .i_we         (w_h1_we),
    .i_le         (w_h1_le),
    .i_ctrl       (w_h1_ctrl),
    .i_done       (done1_c),
    .i_dram_odata (w_dram_odata),
    .o_pend       (pend1),
    .o_addr       (s1_addr),
    .o_wdata      (s1_wdata),
    .o_req        (s1_req),
    .o_odata      (w_h1_odata),
    .o_busy_c     (w_h1_busy)
  );

  assign win_c     = pick_winner(pend0, pend1, rr_last_q, (FAIR != 0));
  assign win_req_c = win_c ? s1_req : s0_req;
  assign done0_c   = done_c & (owner_q == HART0);
  assign done1_c   = done_c & (owner_q == HART1);

  // Arbitration FSM next-state and controller-side outputs.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    daddr_d   = daddr_q;
    dwdata_d  = dwdata_q;
    dctrl_d   = dctrl_q;
    dwe_d     = 1'b0;
    dle_d     = 1'b0;
    done_c    = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        daddr_d  = '0;
        dwdata_d = '0;
        dctrl_d  = '0;
        if (pend0 || pend1) begin
          owner_d  = win_c;
          state_d  = ARB_ISSUE;
          daddr_d  = win_c ? s1_addr  : s0_addr;
          dwdata_d = win_c ? s1_wdata : s0_wdata;
          dctrl_d  = win_req_c.ctrl;
          dwe_d    = win_req_c.we;
          dle_d    = win_req_c.le;
        end
      end
      ARB_ISSUE: begin
        state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (!w_dram_busy) begin
          done_c    = 1'b1;
          rr_last_d = owner_q;
          state_d   = ARB_IDLE;
          daddr_d   = '0;
          dwdata_d  = '0;
          dctrl_d   = '0;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // FSM and output registers; rr_last starts at hart 1 so hart 0 wins the first tie.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q   <= ARB_IDLE;
      owner_q   <= HART0;
      rr_last_q <= HART1;
      daddr_q   <= '0;
      dwdata_q  <= '0;
      dctrl_q   <= '0;
      dwe_q     <= 1'b0;
      dle_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      daddr_q   <= daddr_d;
      dwdata_q  <= dwdata_d;
      dctrl_q   <= dctrl_d;
      dwe_q     <= dwe_d;
      dle_q     <= dle_d;
    end
  end

  assign w_grant      = GRANT_W'(owner_q);
  assign w_dram_addr  = daddr_q;
  assign w_dram_wdata = dwdata_q;
  assign w_dram_ctrl  = dctrl_q;
  assign w_dram_we    = dwe_q;
  assign w_dram_le    = dle_q;

`ifdef DRAM_ARB_STATS_EN
  logic [STAT_W-1:0] sg0_q, sg0_d;
  logic [STAT_W-1:0] sg1_q, sg1_d;
  logic [STAT_W-1:0] scf_q, scf_d;

  // Saturating grant and conflict counters.
  always_comb begin
    sg0_d = sg0_q;
    sg1_d = sg1_q;
    scf_d = scf_q;
    if (state_q == ARB_ISSUE && owner_q == HART0 && sg0_q != '1) sg0_d = sg0_q + STAT_W'(1);
    if (state_q == ARB_ISSUE && owner_q == HART1 && sg1_q != '1) sg1_d = sg1_q + STAT_W'(1);
    if (pend0 && pend1 && scf_q != '1) scf_d = scf_q + STAT_W'(1);
  end

  // Statistics registers.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      sg0_q <= '0;
      sg1_q <= '0;
      scf_q <= '0;
    end else begin
      sg0_q <= sg0_d;
      sg1_q <= sg1_d;
      scf_q <= scf_d;
    end
  end

  assign w_stat_grant0   = sg0_q;
  assign w_stat_grant1   = sg1_q;
  assign w_stat_conflict = scf_q;
`endif

endmodule

// File: tb/tb_dram_arbiter2.sv
// Directed bench for dram_arbiter2: a fair instance and a fixed-priority
// instance share hart stimulus; each has its own simple DRAM controller model.
module tb_dram_arbiter2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] h0_addr = '0, h1_addr = '0, h0_wdata = '0, h1_wdata = '0;
  logic        h0_we = 1'b0, h1_we = 1'b0, h0_le = 1'b0, h1_le = 1'b0;
  logic [2:0]  h0_ctrl = '0, h1_ctrl = '0;

  // Fair instance (a_) and fixed-priority instance (b_) outputs.
  logic        a_b0, a_b1, b_b0, b_b1;
  logic [31:0] a_o0, a_o1, b_o0, b_o1, a_grant, b_grant;
  logic [31:0] a_addr, b_addr, a_wdata, b_wdata;
  logic        a_we, a_le, b_we, b_le, a_busy, b_busy;
  logic [2:0]  a_ctrl, b_ctrl;
  logic [31:0] rd_val = '0;
`ifdef DRAM_ARB_STATS_EN
  logic [31:0] a_sg0, a_sg1, a_scf, b_sg0, b_sg1, b_scf;
`endif

  dram_arbiter2 #(.AW(32), .DW(32), .FAIR(1)) u_fair (
    .CLK(clk), .RST_X(rst_n),
    .w_h0_addr(h0_addr), .w_h1_addr(h1_addr), .w_h0_wdata(h0_wdata), .w_h1_wdata(h1_wdata),
    .w_h0_we(h0_we), .w_h1_we(h1_we), .w_h0_le(h0_le), .w_h1_le(h1_le),
    .w_h0_ctrl(h0_ctrl), .w_h1_ctrl(h1_ctrl), .w_h0_busy(a_b0), .w_h1_busy(a_b1),
    .w_h0_odata(a_o0), .w_h1_odata(a_o1), .w_grant(a_grant),
    .w_dram_addr(a_addr), .w_dram_wdata(a_wdata), .w_dram_we(a_we), .w_dram_le(a_le),
    .w_dram_ctrl(a_ctrl), .w_dram_busy(a_busy), .w_dram_odata(rd_val)
`ifdef DRAM_ARB_STATS_EN
    , .w_stat_grant0(a_sg0), .w_stat_grant1(a_sg1), .w_stat_conflict(a_scf)
`endif
  );

  dram_arbiter2 #(.AW(32), .DW(32), .FAIR(0)) u_fix (
    .CLK(clk), .RST_X(rst_n),
    .w_h0_addr(h0_addr), .w_h1_addr(h1_addr), .w_h0_wdata(h0_wdata), .w_h1_wdata(h1_wdata),
    .w_h0_we(h0_we), .w_h1_we(h1_we), .w_h0_le(h0_le), .w_h1_le(h1_le),
    .w_h0_ctrl(h0_ctrl), .w_h1_ctrl(h1_ctrl), .w_h0_busy(b_b0), .w_h1_busy(b_b1),
    .w_h0_odata(b_o0), .w_h1_odata(b_o1), .w_grant(b_grant),
    .w_dram_addr(b_addr), .w_dram_wdata(b_wdata), .w_dram_we(b_we), .w_dram_le(b_le),
    .w_dram_ctrl(b_ctrl), .w_dram_busy(b_busy), .w_dram_odata(rd_val)
`ifdef DRAM_ARB_STATS_EN
    , .w_stat_grant0(b_sg0), .w_stat_grant1(b_sg1), .w_stat_conflict(b_scf)
`endif
  );

  // Controller model: busy for `lat` cycles starting the cycle after a strobe.
  int lat = 3;
  int cnt_a = 0, cnt_b = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a <= 0;
      cnt_b <= 0;
    end else begin
      if (a_we || a_le) cnt_a <= lat; else if (cnt_a != 0) cnt_a <= cnt_a - 1;
      if (b_we || b_le) cnt_b <= lat; else if (cnt_b != 0) cnt_b <= cnt_b - 1;
    end
  end
  assign a_busy = (cnt_a != 0);
  assign b_busy = (cnt_b != 0);

  // Issue log of every controller strobe.
  typedef struct {
    int          cyc;
    logic [31:0] grant;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ctrl;
    logic        we;
    logic        le;
  } iss_t;
  iss_t log_a[$];
  iss_t log_b[$];
  always @(negedge clk) begin
    if (a_we || a_le) log_a.push_back('{cyc, a_grant, a_addr, a_wdata, a_ctrl, a_we, a_le});
    if (b_we || b_le) log_b.push_back('{cyc, b_grant, b_addr, b_wdata, b_ctrl, b_we, b_le});
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic pulse(input bit h, input bit we, input bit le, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] c);
    if (!h) begin
      h0_addr = a; h0_wdata = d; h0_ctrl = c; h0_we = we; h0_le = le;
    end else begin
      h1_addr = a; h1_wdata = d; h1_ctrl = c; h1_we = we; h1_le = le;
    end
  endtask

  task automatic clear_strobes();
    h0_we = 1'b0; h0_le = 1'b0; h1_we = 1'b0; h1_le = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    @(negedge clk);
    while ((a_b0 || a_b1 || b_b0 || b_b1) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 64'(k < 200), 64'd1);
  endtask

  task automatic do_reset();
    clear_strobes();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    log_a.delete();
    log_b.delete();
  endtask

  typedef struct {
    bit          h;
    bit          we;
    bit          le;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ctrl;
    logic [31:0] rdata;
    int          lat;
    logic [31:0] exp_odata;
    int          exp_busy;
    bit          exp_we;
  } vec_t;
  vec_t vecs[6];

  int sc, bcnt, d0;
  logic bh, other;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b1, 32'h8000_1000, 32'h0, 3'b010, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 7, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h8000_0040, 32'h0, 3'b100, 32'h1234_5678, 1, 32'h1234_5678, 5, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h8000_2000, 32'hCAFE_F00D, 3'b010, 32'h5555_5555, 2, 32'hDEAD_BEEF, 6, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h8000_0080, 32'hA5A5_A5A5, 3'b001, 32'h6666_6666, 0, 32'h1234_5678, 4, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 32'h8000_FFFC, 32'h0, 3'b110, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 4, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h0, 3'b000, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFF, 9, 1'b0};

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {a_b0, a_b1, b_b0, b_b1}, 64'd0);
    chk("rst_odata", {a_o0, a_o1}, 64'd0);
    chk("rst_grant", a_grant, 64'd0);
    chk("rst_dram", {a_addr, a_we, a_le, a_ctrl}, 64'd0);
    rst_n = 1'b1;

    // Uncontended single requests.
    foreach (vecs[i]) begin
      wait_idle("vec_idle");
      log_a.delete();
      lat = vecs[i].lat;
      rd_val = vecs[i].rdata;
      @(posedge clk); #1;
      pulse(vecs[i].h, vecs[i].we, vecs[i].le, vecs[i].addr, vecs[i].wdata, vecs[i].ctrl);
      sc = cyc;
      bcnt = 0;
      @(negedge clk);
      bh = vecs[i].h ? a_b1 : a_b0;
      if (bh) bcnt++;
      @(posedge clk); #1;
      clear_strobes();
      for (int k = 0; k < 60; k++) begin
        @(negedge clk);
        bh = vecs[i].h ? a_b1 : a_b0;
        if (bh) bcnt++;
        else break;
      end
      other = vecs[i].h ? a_b0 : a_b1;
      chk($sformatf("v%0d_busy_cycles", i), 64'(bcnt), 64'(vecs[i].exp_busy));
      chk($sformatf("v%0d_other_busy", i), 64'(other), 64'd0);
      chk($sformatf("v%0d_odata", i), vecs[i].h ? a_o1 : a_o0, vecs[i].exp_odata);
      chk($sformatf("v%0d_grant_hold", i), a_grant, 64'(vecs[i].h));
      chk($sformatf("v%0d_dram_idle", i), {a_addr, a_wdata, a_we, a_le, a_ctrl}, 64'd0);
      chk($sformatf("v%0d_n_issue", i), 64'(log_a.size()), 64'd1);
      if (log_a.size() == 1) begin
        chk($sformatf("v%0d_latency", i), 64'(log_a[0].cyc - sc), 64'd2);
        chk($sformatf("v%0d_addr", i), log_a[0].addr, vecs[i].addr);
        chk($sformatf("v%0d_wdata", i), log_a[0].wdata, vecs[i].wdata);
        chk($sformatf("v%0d_ctrl", i), 64'(log_a[0].ctrl), 64'(vecs[i].ctrl));
        chk($sformatf("v%0d_we_le", i), {log_a[0].we, log_a[0].le}, {vecs[i].exp_we, ~vecs[i].exp_we});
        chk($sformatf("v%0d_grant", i), log_a[0].grant, 64'(vecs[i].h));
      end
    end

    // Simultaneous strobes after reset: hart 0 first in both instances.
    do_reset();
    lat = 3;
    rd_val = 32'h0000_0077;
    @(posedge clk); #1;
    pulse(1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'h11, 3'b010);
    pulse(1'b1, 1'b0, 1'b1, 32'h8000_0004, 32'h0, 3'b010);
    @(posedge clk); #1;
    clear_strobes();
    wait_idle("s2_idle");
    chk("s2_n_issue_a", 64'(log_a.size()), 64'd2);
    chk("s2_n_issue_b", 64'(log_b.size()), 64'd2);
    if (log_a.size() == 2 && log_b.size() == 2) begin
      chk("s2_a_first", {log_a[0].grant, log_a[0].addr}, {32'd0, 32'h8000_0000});
      chk("s2_a_first_wr", {log_a[0].we, log_a[0].wdata}, {1'b1, 32'h11});
      chk("s2_a_second", {log_a[1].grant, log_a[1].addr}, {32'd1, 32'h8000_0004});
      chk("s2_a_gap", 64'(log_a[1].cyc - log_a[0].cyc), 64'd6);
      chk("s2_b_order", {log_b[0].grant[0], log_b[1].grant[0]}, 64'b01);
    end
    chk("s2_h1_odata", a_o1, 64'h77);
    chk("s2_h0_odata", a_o0, 64'h0);

    // Make rr_last = 0, then contend: fair serves hart 1 first, fixed serves hart 0.
    lat = 1;
    rd_val = 32'h0000_3333;
    @(posedge clk); #1;
    pulse(1'b0, 1'b0, 1'b1, 32'h8000_0100, 32'h0, 3'b010);
    @(posedge clk); #1;
    clear_strobes();
    wait_idle("s3_solo_idle");
    log_a.delete();
    log_b.delete();
    lat = 2;
    @(posedge clk); #1;
    pulse(1'b0, 1'b0, 1'b1, 32'h8000_0200, 32'h0, 3'b010);
    pulse(1'b1, 1'b0, 1'b1, 32'h8000_0204, 32'h0, 3'b010);
    @(posedge clk); #1;
    clear_strobes();
    wait_idle("s3_idle");
    chk("s3_n_issue", {32'(log_a.size()), 32'(log_b.size())}, {32'd2, 32'd2});
    if (log_a.size() == 2 && log_b.size() == 2) begin
      chk("s3_fair_order", {log_a[0].grant[0], log_a[1].grant[0]}, 64'b10);
      chk("s3_fix_order", {log_b[0].grant[0], log_b[1].grant[0]}, 64'b01);
      chk("s3_fair_addr0", log_a[0].addr, 64'h8000_0204);
    end

    // Hart 1 re-strobes on its own completion cycle.
    log_a.delete();
    log_b.delete();
    lat = 3;
    rd_val = 32'h0000_4444;
    @(posedge clk); #1;
    pulse(1'b1, 1'b0, 1'b1, 32'h8000_0300, 32'h0, 3'b011);
    sc = cyc;
    @(posedge clk); #1;
    clear_strobes();
    repeat (5) @(posedge clk);
    #1;
    chk("s4_cyc", 64'(cyc - sc), 64'd6);
    chk("s4_busy_before", 64'(a_b1), 64'd1);
    pulse(1'b1, 1'b1, 1'b0, 32'h8000_0304, 32'h99, 3'b010);
    @(posedge clk); #1;
    clear_strobes();
    wait_idle("s4_idle");
    chk("s4_n_issue", {32'(log_a.size()), 32'(log_b.size())}, {32'd2, 32'd2});
    if (log_a.size() == 2) begin
      chk("s4_second", {log_a[1].addr, log_a[1].wdata}, {32'h8000_0304, 32'h99});
      chk("s4_second_we", {log_a[1].we, log_a[1].grant}, {1'b1, 32'd1});
      chk("s4_gap", 64'(log_a[1].cyc - log_a[0].cyc), 64'd6);
    end
    chk("s4_h1_odata", a_o1, 64'h4444);

    // Asynchronous reset during WAIT, then a clean load.
    log_a.delete();
    lat = 3;
    rd_val = 32'h0000_5555;
    @(posedge clk); #1;
    pulse(1'b0, 1'b0, 1'b1, 32'h8000_0400, 32'h0, 3'b010);
    @(posedge clk); #1;
    clear_strobes();
    repeat (3) @(posedge clk);
    #1;
    chk("s5_addr_held", a_addr, 64'h8000_0400);
    chk("s5_busy_pre", 64'(a_b0), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_rst_busy", {a_b0, a_b1}, 64'd0);
    chk("s5_rst_dram", {a_addr, a_we, a_le, a_ctrl}, 64'd0);
    chk("s5_rst_odata", {a_o0, a_o1}, 64'd0);
    chk("s5_rst_grant", a_grant, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    log_a.delete();
    lat = 2;
    rd_val = 32'hBEEF_0001;
    @(posedge clk); #1;
    pulse(1'b0, 1'b0, 1'b1, 32'h8000_0500, 32'h0, 3'b010);
    sc = cyc;
    @(posedge clk); #1;
    clear_strobes();
    wait_idle("s5_idle");
    chk("s5_n_issue", 64'(log_a.size()), 64'd1);
    if (log_a.size() == 1) chk("s5_latency", 64'(log_a[0].cyc - sc), 64'd2);
    chk("s5_odata", a_o0, 64'hBEEF_0001);

    // Five contended pairs from reset.
    do_reset();
    lat = 1;
    for (int p = 0; p < 5; p++) begin
      @(posedge clk); #1;
      pulse(1'b0, 1'b0, 1'b1, 32'h8000_0600, 32'h0, 3'b010);
      pulse(1'b1, 1'b0, 1'b1, 32'h8000_0604, 32'h0, 3'b010);
      @(posedge clk); #1;
      clear_strobes();
      wait_idle("s6_idle");
    end
    chk("s6_n_issue", {32'(log_a.size()), 32'(log_b.size())}, {32'd10, 32'd10});
    d0 = 0;
    foreach (log_a[i]) if (log_a[i].grant[0] == 1'b0) d0++;
    chk("s6_h0_grants", 64'(d0), 64'd5);
`ifdef DRAM_ARB_STATS_EN
    chk("s6_stat_grant0", a_sg0, 64'd5);
    chk("s6_stat_grant1", a_sg1, 64'd5);
    chk("s6_stat_conflict", 64'(a_scf != 0), 64'd1);
    chk("s6_fix_stats", {b_sg0, b_sg1}, {32'd5, 32'd5});
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dram_arbiter2.md
Name: dram_arbiter2

Overview:
- Two-hart DRAM arbiter between the per-hart cpummu DRAM-side ports and the single DRAM controller.
- Captures each hart's single-cycle load/store strobe and queues one request per hart.
- Serialises the queued requests onto one DRAM port, round-robin or fixed priority.
- Returns per-hart busy and read data, and drives the owner hart id as w_grant to both harts.

Parameters:
- AW, 32, address width
- DW, 32, data width
- FAIR, 1: 1 = round-robin, 0 = hart 0 always wins a tie

Ports:
- CLK  in  1  clock
- RST_X  in  1  asynchronous active-low reset
- w_h0_addr / w_h1_addr  in  AW  hart request address
- w_h0_wdata / w_h1_wdata  in  DW  hart write data
- w_h0_we / w_h1_we  in  1  write strobe, one cycle
- w_h0_le / w_h1_le  in  1  load strobe, one cycle
- w_h0_ctrl / w_h1_ctrl  in  3  size/sign control
- w_h0_busy / w_h1_busy  out  1  hart-side busy
- w_h0_odata / w_h1_odata  out  DW  hart read data
- w_grant  out  32  hart id of current/last owner
- w_dram_addr  out  AW  controller address
- w_dram_wdata  out  DW  controller write data
- w_dram_we  out  1  controller write strobe
- w_dram_le  out  1  controller load strobe
- w_dram_ctrl  out  3  controller control
- w_dram_busy  in  1  controller busy
- w_dram_odata  in  DW  controller read data

Behaviour:
- Reset values: all outputs 0, except w_grant = 0 (hart 0). pend0 = pend1 = 0. State IDLE. rr_last = 1, so hart 0 wins the first tie.
- Capture:
  - A strobe (we|le) from hart i while pend_i == 0 latches addr, wdata, ctrl, we, le into slot i and sets pend_i on the next edge.
  - A strobe while pend_i == 1 is a protocol violation and is ignored. The hart must wait for busy low.
  - we and le both set in one strobe: treated as a write.
- Hart busy: w_hi_busy = strobe_i | pend_i, combinational. It is high in the strobe cycle and stays high until the cycle after the read data is valid.
- States:
  - IDLE: if pend0|pend1, select the winner.
    - Both pending: FAIR=1 picks the hart other than rr_last; FAIR=0 picks hart 0.
    - Register owner, drive w_grant = owner, go to ISSUE.
  - ISSUE: one cycle. Drive w_dram_addr/wdata/ctrl from the owner slot and pulse w_dram_we or w_dram_le. Go to WAIT.
  - WAIT:
    - Stay while w_dram_busy == 1. w_dram_busy low in the first WAIT cycle is legal; the controller asserts busy from the cycle after the strobe.
    - On the first WAIT cycle with w_dram_busy == 0: latch w_dram_odata into odata_owner (loads only; writes leave odata unchanged), clear pend_owner, set rr_last = owner, go to IDLE.
- Latency: an uncontended request reaches the DRAM strobe 2 cycles after the hart strobe (capture, IDLE select, ISSUE). Hart busy drops 1 cycle after the controller busy drops.
- Back-to-back: the IDLE cycle after a completion may immediately select the other pending hart. There is no dead cycle beyond IDLE.
- Same-cycle events: a strobe from hart i in the same cycle pend_i clears (completion) is captured. New pend_i takes priority over the clear.
- w_grant holds the last owner while IDLE with nothing pending.
- DRAM outputs are 0 outside the ISSUE cycle, except addr/wdata/ctrl, which hold the owner slot through WAIT.
- Reset mid-operation: all state clears immediately and asynchronously. An in-flight controller transaction is abandoned, and the controller is reset by the same RST_X.

Optional Feature:
- Macro: DRAM_ARB_STATS_EN.
- When defined, adds these outputs, cleared on reset:
  - w_stat_grant0 (32)
  - w_stat_grant1 (32)
  - w_stat_conflict (32)
- w_stat_grant0/1 increment on each ISSUE for that owner, saturating at 0xFFFFFFFF.
- w_stat_conflict increments each cycle where both pend bits are set, also saturating.
- When undefined: ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package/header (define.vh): state encodings ARB_IDLE=0, ARB_ISSUE=1, ARB_WAIT=2; hart id constants.
- One natural sub-module, dram_arb_slot: the per-hart request latch, pend flag and odata register, instantiated twice.
- Winner selection and the FSM stay in the top module.

Test Plan:
1. Hart 0 load, addr 0x80001000. The DRAM model holds busy 3 cycles and returns 0xDEADBEEF.
   - w_dram_le pulses 2 cycles after the strobe; w_h0_odata = 0xDEADBEEF.
   - w_h0_busy is high 7 cycles total; w_grant = 0.
2. Both harts strobe in the same cycle after reset: h0 store 0x11 @0x80000000, h1 load @0x80000004.
   - h0 is issued first, then h1 on the IDLE cycle after h0 completes; w_grant goes 0 then 1.
3. Same as scenario 2 but rr_last = 0, FAIR=1: h1 is served first. With FAIR=0: h0 is served first.
4. Hart 1 strobes again in the cycle its pend clears: the second request is captured and issued with no lost strobe.
5. Assert RST_X low during WAIT: all outputs become 0 asynchronously and pend bits clear. After release, a new h0 load completes normally.
6. DRAM_ARB_STATS_EN defined, 5 contended pairs issued: w_stat_grant0 = 5, w_stat_grant1 = 5, w_stat_conflict > 0.
